wide_arith_seq: RTL and testbench
=================================

WIDE_ARITH_SEQ -- requirements
Module: wide_arith_seq

Interface
- REQ-001 The block SHALL have parameter N, default 32: limb width, equal to the ALU operand width.
- REQ-002 The block SHALL have parameter LIMBS, default 4: limbs per operand, with LIMBS >= 2.
- REQ-003 The block SHALL have the following ports:
  - clk  in  1  the single clock; all state changes on the rising edge.
  - rst  in  1  synchronous, active-high reset.
  - start  in  1  request; accepted only in IDLE.
  - op  in  3  operation: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR; 101-111 are reserved.
  - op_a  in  N*LIMBS  wide operand A; limb 0 is the least significant.
  - op_b  in  N*LIMBS  wide operand B.
  - busy  out  1  high while a request is in progress.
  - done  out  1  one-cycle pulse when result and status are valid.
  - result  out  N*LIMBS  wide result, registered.
  - status  out  4  {N,Z,C,V} of the wide result, registered.
  - alu_a  out  N  current limb of A, driven to the ALU.
  - alu_b  out  N  current limb of B, driven to the ALU.
  - alu_carry_in  out  1  ALU carryIn.
  - alu_exe_cmd  out  4  ALU exeCmd.
  - alu_out  in  N  combinational ALU result.
  - alu_status  in  4  combinational ALU {n,z,c,v}.

Function
- REQ-004 The block SHALL implement FSM states IDLE, RUN and DONE, with these transitions:
  - IDLE->RUN on start.
  - RUN->DONE after limb LIMBS-1 is processed.
  - DONE->IDLE unconditionally.
- REQ-005 On start in IDLE, the block SHALL latch op_a, op_b and op, clear the limb index to 0, and clear the internal carry and zero-accumulator (zero-acc set to 1).
- REQ-006 The block SHALL ignore start in RUN and DONE, with no effect on latched operands.
- REQ-007 In RUN, the block SHALL process exactly one limb per cycle, in order 0..LIMBS-1, with alu_a/alu_b equal to latched limb[index].
- REQ-008 For limb 0, alu_exe_cmd SHALL be: ADD->0010, SUB->0100, AND->0110, ORR->0111, EOR->1000.
- REQ-009 For limbs >0, alu_exe_cmd SHALL be ADD->0011 (ADC) and SUB->0101 (SBC); logic ops SHALL keep the same code as limb 0.
- REQ-010 alu_carry_in SHALL be as follows:
  - ADC: the registered alu_status C from the previous limb.
  - SBC: the inverse of that registered C, since the ALU C flag denotes borrow on subtract and SBC subtracts ~carryIn.
  - All other cycles: 0.
- REQ-011 In each RUN cycle, the block SHALL register alu_out into result limb[index] and AND (alu_out==0) into the zero-accumulator.
- REQ-012 In each RUN cycle, the block SHALL register alu_status C for the next limb.
- REQ-013 On the last limb, status SHALL be formed as follows:
  - N = alu_out[N-1].
  - Z = final zero-accumulator.
  - C = alu_status C.
  - V = alu_status V.
- REQ-014 Z in status SHALL reflect the entire wide result, not the last limb alone.
- REQ-015 In IDLE and DONE, the block SHALL drive alu_exe_cmd=0000, alu_a=0, alu_b=0 and alu_carry_in=0.
- REQ-016 Latency SHALL be fixed: start sampled at edge k gives RUN for edges k+1..k+LIMBS, and done high in the cycle after edge k+LIMBS, with a total of LIMBS+1 cycles from start to done.
- REQ-017 busy SHALL be high in RUN and DONE and low in IDLE.
- REQ-018 done SHALL be high only in DONE.
- REQ-019 A new start SHALL be accepted in the cycle after done, giving a back-to-back throughput of one request per LIMBS+2 cycles.
- REQ-020 result and status SHALL hold their values from the last completed operation until the next operation writes them.
- REQ-021 Partially written limbs SHALL be visible during RUN, but result SHALL be valid only when done is high.
- REQ-022 A reserved op SHALL run the normal RUN sequence with alu_exe_cmd=0000, giving result=0 and status={0,1,0,0}.
- REQ-023 The internal carry register SHALL be cleared on every start, so no carry is carried across requests.

Reset
- REQ-024 While rst is high, the block SHALL force state IDLE, limb index 0, carry 0, zero-acc 1, busy=0, done=0, result=0 and status=0000.
- REQ-025 rst SHALL take priority over start and over an operation in progress.
- REQ-026 A reset mid-RUN SHALL abandon the operation with no done pulse.

Verification (N=32, LIMBS=4)
- REQ-027 ADD carry ripple: A=0x00000000_00000000_FFFFFFFF_FFFFFFFF, B=1 -> result=0x00000000_00000001_00000000_00000000, status=0000, done exactly 5 cycles after start.
- REQ-028 SUB borrow: A=0, B=1 -> result=all ones, status N=1,Z=0,C=1,V=0; limbs 1..3 use exeCmd 0101 with alu_carry_in=0.
- REQ-029 Signed overflow: ADD A=0x7FFF...FFFF, B=1 -> result=0x8000...0000, status N=1,Z=0,C=0,V=1.
- REQ-030 Wide zero: EOR A=B=0x12345678_00000000_00000000_9ABCDEF0 -> result=0, Z=1.
- REQ-031 Zero flag, last limb zero only: ADD A=0x00000000_00000000_00000000_00000005, B=0 -> Z=0 despite a zero top limb.
- REQ-032 Reset and start handling:
  - rst asserted in the 2nd RUN cycle -> next cycle busy=0, done=0, result=0, status=0, alu_exe_cmd=0000.
  - A subsequent start completes normally.
  - start pulses during busy are ignored and leave result unchanged.

Source files
------------

// File: rtl/wide_arith_seq.sv
// Multi-limb arithmetic/logic sequencer: drives an external N-bit ALU one limb per
// cycle, chaining carry/borrow and accumulating a wide zero flag.
module wide_arith_seq #(
    parameter int unsigned N     = 32,
    parameter int unsigned LIMBS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [N*LIMBS-1:0]   op_a,
    input  logic [N*LIMBS-1:0]   op_b,
    output logic                 busy,
    output logic                 done,
    output logic [N*LIMBS-1:0]   result,
    output logic [3:0]           status,
    output logic [N-1:0]         alu_a,
    output logic [N-1:0]         alu_b,
    output logic                 alu_carry_in,
    output logic [3:0]           alu_exe_cmd,
    input  logic [N-1:0]         alu_out,
    input  logic [3:0]           alu_status
);

    localparam int unsigned IDXW = (LIMBS > 1) ? $clog2(LIMBS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state;
    state_t                   stateNext;
    logic [IDXW-1:0]          limbIdx;
    logic [LIMBS-1:0][N-1:0]  latA;
    logic [LIMBS-1:0][N-1:0]  latB;
    logic [2:0]               latOp;
    logic                     carry;
    logic                     zeroAcc;
    logic [LIMBS-1:0][N-1:0]  resultQ;
    logic [3:0]               statusQ;
    logic                     lastLimb;
    logic                     firstLimb;
    logic                     zeroNext;
    logic                     unusedAluFlags;

    assign lastLimb       = (limbIdx == IDXW'(LIMBS - 1));
    assign firstLimb      = (limbIdx == '0);
    assign zeroNext       = zeroAcc & (alu_out == '0);
    assign unusedAluFlags = &{1'b0, alu_status[3:2]};
    assign result         = resultQ;
    assign status         = statusQ;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = RUN;
            RUN:     if (lastLimb) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // ALU drive and handshake outputs
    always_comb begin
        busy         = (state == RUN) || (state == DONE);
        done         = (state == DONE);
        alu_a        = '0;
        alu_b        = '0;
        alu_carry_in = 1'b0;
        alu_exe_cmd  = 4'b0000;
        if (state == RUN) begin
            alu_a = latA[limbIdx];
            alu_b = latB[limbIdx];
            case (latOp)
                3'b000: begin
                    alu_exe_cmd  = firstLimb ? 4'b0010 : 4'b0011;
                    alu_carry_in = firstLimb ? 1'b0 : carry;
                end
                3'b001: begin
                    // ALU C is a borrow on subtract; SBC subtracts ~carryIn
                    alu_exe_cmd  = firstLimb ? 4'b0100 : 4'b0101;
                    alu_carry_in = firstLimb ? 1'b0 : ~carry;
                end
                3'b010:  alu_exe_cmd = 4'b0110;
                3'b011:  alu_exe_cmd = 4'b0111;
                3'b100:  alu_exe_cmd = 4'b1000;
                default: alu_exe_cmd = 4'b0000;
            endcase
        end
    end

    // Operand latch, limb sequencing and result/status capture
    always_ff @(posedge clk) begin
        if (rst) begin
            limbIdx <= '0;
            latA    <= '0;
            latB    <= '0;
            latOp   <= '0;
            carry   <= 1'b0;
            zeroAcc <= 1'b1;
            resultQ <= '0;
            statusQ <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        latA    <= op_a;
                        latB    <= op_b;
                        latOp   <= op;
                        limbIdx <= '0;
                        carry   <= 1'b0;
                        zeroAcc <= 1'b1;
                    end
                end
                RUN: begin
                    resultQ[limbIdx] <= alu_out;
                    zeroAcc          <= zeroNext;
                    carry            <= alu_status[1];
                    limbIdx          <= limbIdx + IDXW'(1);
                    if (lastLimb) begin
                        statusQ <= {alu_out[N-1], zeroNext, alu_status[1], alu_status[0]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wide_arith_seq.sv
// Self-checking bench for wide_arith_seq: behavioural ALU plus a wide-arithmetic reference.
module tb_wide_arith_seq;

    localparam int unsigned N     = 32;
    localparam int unsigned LIMBS = 4;
    localparam int unsigned W     = N * LIMBS;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    op;
    logic [W-1:0]  opA;
    logic [W-1:0]  opB;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic [3:0]    status;
    logic [N-1:0]  aluA;
    logic [N-1:0]  aluB;
    logic          aluCarryIn;
    logic [3:0]    aluExeCmd;
    logic [N-1:0]  aluOut;
    logic [3:0]    aluStatus;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wide_arith_seq #(.N(N), .LIMBS(LIMBS)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .op_a(opA), .op_b(opB),
        .busy(busy), .done(done), .result(result), .status(status),
        .alu_a(aluA), .alu_b(aluB), .alu_carry_in(aluCarryIn),
        .alu_exe_cmd(aluExeCmd), .alu_out(aluOut), .alu_status(aluStatus)
    );

    // Behavioural N-bit ALU; C is a borrow flag for SUB/SBC
    logic [N:0] t;
    logic       aluC;
    logic       aluV;
    always_comb begin
        t    = '0;
        aluC = 1'b0;
        aluV = 1'b0;
        case (aluExeCmd)
            4'b0010: t = {1'b0, aluA} + {1'b0, aluB};
            4'b0011: t = {1'b0, aluA} + {1'b0, aluB} + (N+1)'(aluCarryIn);
            4'b0100: t = {1'b0, aluA} - {1'b0, aluB};
            4'b0101: t = {1'b0, aluA} - {1'b0, aluB} - (N+1)'(!aluCarryIn);
            4'b0110: t = {1'b0, aluA & aluB};
            4'b0111: t = {1'b0, aluA | aluB};
            4'b1000: t = {1'b0, aluA ^ aluB};
            default: t = '0;
        endcase
        aluOut = t[N-1:0];
        if (aluExeCmd == 4'b0010 || aluExeCmd == 4'b0011) begin
            aluC = t[N];
            aluV = (aluA[N-1] == aluB[N-1]) && (aluOut[N-1] != aluA[N-1]);
        end else if (aluExeCmd == 4'b0100 || aluExeCmd == 4'b0101) begin
            aluC = t[N];
            aluV = (aluA[N-1] != aluB[N-1]) && (aluOut[N-1] != aluA[N-1]);
        end
        aluStatus = {aluOut[N-1], aluOut == '0, aluC, aluV};
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Whole-operand reference computed with wide arithmetic
    task automatic refCalc(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] r, output logic [3:0] s);
        logic [W:0] sum;
        logic c, v;
        c = 1'b0;
        v = 1'b0;
        case (o)
            3'd0: begin
                sum = {1'b0, a} + {1'b0, b};
                r = sum[W-1:0];
                c = sum[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'd1: begin
                r = a - b;
                c = (a < b);
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            default: r = '0;
        endcase
        s = {r[W-1], r == '0, c, v};
    endtask

    function automatic logic [3:0] expCmd(input logic [2:0] o, input int i);
        case (o)
            3'd0:    return (i == 0) ? 4'b0010 : 4'b0011;
            3'd1:    return (i == 0) ? 4'b0100 : 4'b0101;
            3'd2:    return 4'b0110;
            3'd3:    return 4'b0111;
            3'd4:    return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    // Carry-in expected at limb i, derived from the lower i*N bits of the operands
    function automatic logic expCin(input logic [2:0] o, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input int i);
        logic [W:0] mask;
        logic [W:0] lowA;
        logic [W:0] lowB;
        logic [W:0] s;
        if (i == 0 || o > 3'd1) return 1'b0;
        mask = ({{W{1'b0}}, 1'b1} << (i * N)) - 1;
        lowA = {1'b0, a} & mask;
        lowB = {1'b0, b} & mask;
        if (o == 3'd0) begin
            s = (lowA + lowB) >> (i * N);
            return s[0];
        end
        return !(lowA < lowB);
    endfunction

    function automatic logic [W-1:0] randWide();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Issue one request and check the ALU drive, latency and final result/status
    task automatic runOp(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit pulse);
        logic [W-1:0] er;
        logic [3:0]   es;
        logic [W-1:0] la;
        logic [W-1:0] lb;
        int edges;
        refCalc(o, a, b, er, es);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        opA   = a;
        opB   = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        edges = 0;
        la = a;
        lb = b;
        for (int i = 0; i < LIMBS; i++) begin
            check({tag, " busy"}, W'(busy), W'(1));
            check({tag, " aluA"}, W'(aluA), W'(la[i*N +: N]));
            check({tag, " aluB"}, W'(aluB), W'(lb[i*N +: N]));
            check({tag, " cmd"}, W'(aluExeCmd), W'(expCmd(o, i)));
            check({tag, " cin"}, W'(aluCarryIn), W'(expCin(o, a, b, i)));
            if (pulse && i == 1) begin
                start = 1'b1;
                op    = o ^ 3'd1;
                opA   = ~a;
                opB   = randWide();
            end else begin
                start = 1'b0;
            end
            check({tag, " early done"}, W'(done), W'(0));
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        start = 1'b0;
        while (!done && edges < LIMBS + 4) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check({tag, " latency"}, W'(edges), W'(LIMBS));
        check({tag, " result"}, result, er);
        check({tag, " status"}, W'(status), W'(es));
        check({tag, " idle cmd in done"}, W'(aluExeCmd), W'(0));
        if (pulse) start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({tag, " done pulse"}, W'(done), W'(0));
        check({tag, " busy idle"}, W'(busy), W'(0));
        check({tag, " hold result"}, result, er);
        check({tag, " hold status"}, W'(status), W'(es));
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        rst   = 1'b1;
        start = 1'b0;
        op    = '0;
        opA   = '0;
        opB   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", W'(busy), W'(0));
        check("reset done", W'(done), W'(0));
        check("reset result", result, '0);
        check("reset status", W'(status), W'(0));
        rst = 1'b0;
        @(negedge clk);
        check("idle cmd", W'(aluExeCmd), W'(0));
        check("idle aluA", W'(aluA), W'(0));
        check("idle cin", W'(aluCarryIn), W'(0));

        runOp("add ripple", 3'd0, 128'h00000000_00000000_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0);
        check("add ripple value", result, 128'h00000000_00000001_00000000_00000000);
        check("add ripple flags", W'(status), W'(4'b0000));
        runOp("sub borrow", 3'd1, 128'd0, 128'd1, 1'b0);
        check("sub borrow value", result, {W{1'b1}});
        check("sub borrow flags", W'(status), W'(4'b1010));
        runOp("add ovf", 3'd0, {1'b0, {(W-1){1'b1}}}, 128'd1, 1'b0);
        check("add ovf flags", W'(status), W'(4'b1001));
        runOp("eor zero", 3'd4, 128'h12345678_00000000_00000000_9ABCDEF0,
              128'h12345678_00000000_00000000_9ABCDEF0, 1'b0);
        check("eor zero flags", W'(status), W'(4'b0100));
        runOp("add low only", 3'd0, 128'd5, 128'd0, 1'b0);
        check("add low only Z", W'(status[2]), W'(0));
        runOp("reserved", 3'd6, randWide(), randWide(), 1'b0);
        check("reserved flags", W'(status), W'(4'b0100));
        runOp("busy pulses", 3'd1, randWide(), randWide(), 1'b1);

        // Reset in the second RUN cycle abandons the request
        @(negedge clk);
        start = 1'b1;
        op    = 3'd0;
        opA   = randWide();
        opB   = randWide();
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrun busy", W'(busy), W'(0));
        check("midrun done", W'(done), W'(0));
        check("midrun result", result, '0);
        check("midrun status", W'(status), W'(0));
        check("midrun cmd", W'(aluExeCmd), W'(0));
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post reset no done", W'(done), W'(0));
        runOp("after reset", 3'd0, randWide(), randWide(), 1'b0);

        for (int k = 0; k < 24; k++) begin
            a = randWide();
            b = (k % 5 == 0) ? a : randWide();
            if (k % 7 == 3) b = ~a;
            runOp("random", 3'($urandom_range(0, 7)), a, b, 1'(k % 4 == 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
